// File: rtl/ex_operand_stage_if.sv
// Decode-to-execute operand bus: decode capture fields, MEM/WB forward sources and registered EX outputs.
// master drives decode/forward/downstream-ready; slave is the operand stage itself.
interface ex_operand_stage_if;
    logic        valid_d;
    logic        ready_d;
    logic [6:0]  ins_d;
    logic [31:0] rd1_d;
    logic [31:0] rd2_d;
    logic [31:0] imm_d;
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;
    logic [4:0]  rd_d;
    logic        alusrc_d;
    logic        regwrite_d;

    logic [4:0]  rd_m;
    logic [4:0]  rd_w;
    logic        regwrite_m;
    logic        regwrite_w;
    logic [31:0] aluresult_m;
    logic [31:0] result_w;

    logic        flush_e;
    logic        valid_e;
    logic        ready_e;
    logic [6:0]  ins_e;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [31:0] writedata_e;
    logic [4:0]  rd_e;
    logic        regwrite_e;

    modport master (
        output valid_d, ins_d, rd1_d, rd2_d, imm_d, rs1_d, rs2_d, rd_d, alusrc_d, regwrite_d,
        output rd_m, rd_w, regwrite_m, regwrite_w, aluresult_m, result_w,
        output flush_e, ready_e,
        input  ready_d, valid_e, ins_e, SrcAE, SrcBE, writedata_e, rd_e, regwrite_e
    );

    modport slave (
        input  valid_d, ins_d, rd1_d, rd2_d, imm_d, rs1_d, rs2_d, rd_d, alusrc_d, regwrite_d,
        input  rd_m, rd_w, regwrite_m, regwrite_w, aluresult_m, result_w,
        input  flush_e, ready_e,
        output ready_d, valid_e, ins_e, SrcAE, SrcBE, writedata_e, rd_e, regwrite_e
    );
endinterface

// File: rtl/ex_operand_stage.sv
// One-entry EX operand register with MEM/WB forwarding; 1 cycle decode->valid_e, operands combinational.
// Valid/ready: ready_d = (~valid_e | ready_e) & ~flush_e; stalled entries re-latch forwarded operands.
module ex_operand_stage (
    input  logic                 clk,
    input  logic                 reset,
    ex_operand_stage_if.slave    bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state_q;
    state_t      state_nxt;

    logic [6:0]  ins_q;
    logic [31:0] rd1_q;
    logic [31:0] rd2_q;
    logic [31:0] imm_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [4:0]  rd_q;
    logic        alusrc_q;
    logic        regwrite_q;

    logic        full;
    logic        xfer_in;
    logic        stall;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;

    assign full        = (state_q == FULL);
    assign bus.ready_d = (~full | bus.ready_e) & ~bus.flush_e;
    assign xfer_in     = bus.valid_d & bus.ready_d;
    assign stall       = full & ~bus.ready_e;

    always_comb begin
        state_nxt = state_q;
        if (bus.flush_e) begin
            state_nxt = EMPTY;
        end else if (xfer_in) begin
            state_nxt = FULL;
        end else if (full && bus.ready_e) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_nxt;
        end
    end

    // x0 is hardwired zero, so a pending write to it must never be forwarded.
    always_comb begin
        fwd_a = rd1_q;
        if (bus.regwrite_m && (bus.rd_m == rs1_q) && (rs1_q != 5'd0)) begin
            fwd_a = bus.aluresult_m;
        end else if (bus.regwrite_w && (bus.rd_w == rs1_q) && (rs1_q != 5'd0)) begin
            fwd_a = bus.result_w;
        end

        fwd_b = rd2_q;
        if (bus.regwrite_m && (bus.rd_m == rs2_q) && (rs2_q != 5'd0)) begin
            fwd_b = bus.aluresult_m;
        end else if (bus.regwrite_w && (bus.rd_w == rs2_q) && (rs2_q != 5'd0)) begin
            fwd_b = bus.result_w;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ins_q      <= 7'd0;
            rd1_q      <= 32'd0;
            rd2_q      <= 32'd0;
            imm_q      <= 32'd0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rd_q       <= 5'd0;
            alusrc_q   <= 1'b0;
            regwrite_q <= 1'b0;
        end else if (xfer_in) begin
            ins_q      <= bus.ins_d;
            rd1_q      <= bus.rd1_d;
            rd2_q      <= bus.rd2_d;
            imm_q      <= bus.imm_d;
            rs1_q      <= bus.rs1_d;
            rs2_q      <= bus.rs2_d;
            rd_q       <= bus.rd_d;
            alusrc_q   <= bus.alusrc_d;
            regwrite_q <= bus.regwrite_d;
        end else if (stall) begin
            // A forward source may retire while we wait; keep its value.
            rd1_q <= fwd_a;
            rd2_q <= fwd_b;
        end
    end

    assign bus.valid_e     = full;
    assign bus.ins_e       = ins_q;
    assign bus.rd_e        = rd_q;
    assign bus.regwrite_e  = regwrite_q & full;
    assign bus.SrcAE       = fwd_a;
    assign bus.writedata_e = fwd_b;
    assign bus.SrcBE       = alusrc_q ? imm_q : fwd_b;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed scenarios then randomized traffic against a transaction-level reference of the EX operand stage.
module tb_ex_operand_stage;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    ex_operand_stage_if ifc ();

    ex_operand_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.valid_d = 0; ifc.ins_d = 0; ifc.rd1_d = 0; ifc.rd2_d = 0; ifc.imm_d = 0;
        ifc.rs1_d = 0; ifc.rs2_d = 0; ifc.rd_d = 0; ifc.alusrc_d = 0; ifc.regwrite_d = 0;
        ifc.rd_m = 0; ifc.rd_w = 0; ifc.regwrite_m = 0; ifc.regwrite_w = 0;
        ifc.aluresult_m = 0; ifc.result_w = 0; ifc.flush_e = 0; ifc.ready_e = 0;
    endtask

    // Reference: a held instruction record plus the forwarding rule as stated.
    typedef struct {
        logic        vld;
        logic [6:0]  ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        alusrc;
        logic        regwrite;
    } held_t;

    held_t m;

    function automatic logic [31:0] forward(input logic [4:0] rs, input logic [31:0] own);
        if (rs == 0) return own;
        if (ifc.regwrite_m && ifc.rd_m == rs) return ifc.aluresult_m;
        if (ifc.regwrite_w && ifc.rd_w == rs) return ifc.result_w;
        return own;
    endfunction

    initial begin
        logic        exp_rdy;
        logic [31:0] ea;
        logic [31:0] eb;
        n_checks = 0;
        n_pass   = 0;
        idle_inputs();
        reset = 1'b1;
        #12;
        chk("rst_valid_e", {31'd0, ifc.valid_e}, 0);
        chk("rst_regwrite_e", {31'd0, ifc.regwrite_e}, 0);
        chk("rst_ins_e", {25'd0, ifc.ins_e}, 0);
        chk("rst_rd_e", {27'd0, ifc.rd_e}, 0);
        chk("rst_srca", ifc.SrcAE, 0);
        reset = 1'b0;
        #1;
        chk("rst_ready_d", {31'd0, ifc.ready_d}, 1);

        // Basic pass-through
        ifc.valid_d = 1; ifc.ins_d = 7'b0000010; ifc.rd1_d = 5; ifc.rd2_d = 7; ifc.imm_d = 32'h123;
        ifc.rs1_d = 1; ifc.rs2_d = 2; ifc.rd_d = 9; ifc.regwrite_d = 1; ifc.ready_e = 1;
        tick();
        chk("pass_valid_e", {31'd0, ifc.valid_e}, 1);
        chk("pass_srca", ifc.SrcAE, 5);
        chk("pass_srcb", ifc.SrcBE, 7);
        chk("pass_ins_e", {25'd0, ifc.ins_e}, 32'h02);
        chk("pass_rd_e", {27'd0, ifc.rd_e}, 9);
        chk("pass_regwrite_e", {31'd0, ifc.regwrite_e}, 1);

        // MEM over WB priority
        ifc.rs1_d = 3; ifc.rd1_d = 1; ifc.alusrc_d = 1; ifc.imm_d = 32'hABCD;
        tick();
        chk("imm_srcb", ifc.SrcBE, 32'hABCD);
        ifc.valid_d = 0; ifc.ready_e = 0;
        ifc.regwrite_m = 1; ifc.rd_m = 3; ifc.aluresult_m = 32'h10;
        ifc.regwrite_w = 1; ifc.rd_w = 3; ifc.result_w = 32'h20;
        #1;
        chk("mem_prio_srca", ifc.SrcAE, 32'h10);
        ifc.regwrite_m = 0;
        #1;
        chk("wb_fwd_srca", ifc.SrcAE, 32'h20);
        ifc.regwrite_w = 0;
        #1;
        chk("no_fwd_srca", ifc.SrcAE, 1);

        // x0 never forwarded
        ifc.ready_e = 1; ifc.valid_d = 1; ifc.rs2_d = 0; ifc.rd2_d = 0; ifc.alusrc_d = 0;
        tick();
        ifc.valid_d = 0; ifc.ready_e = 0;
        ifc.regwrite_m = 1; ifc.rd_m = 0; ifc.aluresult_m = 32'hFFFF;
        #1;
        chk("x0_writedata", ifc.writedata_e, 0);
        chk("x0_srcb", ifc.SrcBE, 0);
        ifc.regwrite_m = 0;

        // Stall refresh keeps a retired WB value
        ifc.ready_e = 1; ifc.valid_d = 1; ifc.rs1_d = 4; ifc.rd1_d = 1;
        tick();
        ifc.valid_d = 0; ifc.ready_e = 0;
        ifc.regwrite_w = 1; ifc.rd_w = 4; ifc.result_w = 32'h99;
        tick();
        ifc.regwrite_w = 0; ifc.result_w = 0;
        #1;
        chk("stall_srca_0", ifc.SrcAE, 32'h99);
        tick();
        chk("stall_srca_1", ifc.SrcAE, 32'h99);
        chk("stall_valid", {31'd0, ifc.valid_e}, 1);
        ifc.ready_e = 1;
        tick();
        chk("drain_valid", {31'd0, ifc.valid_e}, 0);

        // Flush then back-to-back
        ifc.valid_d = 1; ifc.regwrite_d = 1;
        tick();
        ifc.flush_e = 1; ifc.ready_e = 0;
        #1;
        chk("flush_ready_d", {31'd0, ifc.ready_d}, 0);
        tick();
        chk("flush_valid_e", {31'd0, ifc.valid_e}, 0);
        chk("flush_regwrite_e", {31'd0, ifc.regwrite_e}, 0);
        ifc.flush_e = 0; ifc.ready_e = 1; ifc.rs1_d = 0;
        for (int i = 0; i < 4; i++) begin
            ifc.rd1_d = 100 + i;
            #1;
            chk("b2b_ready_d", {31'd0, ifc.ready_d}, 1);
            tick();
            chk("b2b_valid_e", {31'd0, ifc.valid_e}, 1);
            chk("b2b_srca", ifc.SrcAE, 100 + i);
        end

        // Reset mid-operation is immediate
        ifc.ready_e = 0; ifc.rd_d = 17; ifc.ins_d = 7'h55;
        tick();
        ifc.valid_d = 0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid_e", {31'd0, ifc.valid_e}, 0);
        chk("arst_regwrite_e", {31'd0, ifc.regwrite_e}, 0);
        chk("arst_rd_e", {27'd0, ifc.rd_e}, 0);
        chk("arst_ins_e", {25'd0, ifc.ins_e}, 0);
        reset = 1'b0;
        #1;
        chk("arst_ready_d", {31'd0, ifc.ready_d}, 1);
        tick();
        chk("arst_discard", {31'd0, ifc.valid_e}, 0);

        // Randomized traffic against the reference
        m = '{default: '0};
        for (int cyc = 0; cyc < 600; cyc++) begin
            ifc.valid_d    = ($urandom_range(0, 9) < 7);
            ifc.ins_d      = 7'($urandom);
            ifc.rd1_d      = $urandom;
            ifc.rd2_d      = $urandom;
            ifc.imm_d      = $urandom;
            ifc.rs1_d      = 5'($urandom_range(0, 5));
            ifc.rs2_d      = 5'($urandom_range(0, 5));
            ifc.rd_d       = 5'($urandom);
            ifc.alusrc_d   = 1'($urandom);
            ifc.regwrite_d = 1'($urandom);
            ifc.regwrite_m = 1'($urandom);
            ifc.regwrite_w = 1'($urandom);
            ifc.rd_m       = 5'($urandom_range(0, 5));
            ifc.rd_w       = 5'($urandom_range(0, 5));
            ifc.aluresult_m = $urandom;
            ifc.result_w   = $urandom;
            ifc.flush_e    = ($urandom_range(0, 9) == 0);
            ifc.ready_e    = ($urandom_range(0, 9) < 6);
            #1;
            exp_rdy = (!m.vld || ifc.ready_e) && !ifc.flush_e;
            ea = forward(m.rs1, m.a);
            eb = forward(m.rs2, m.b);
            chk("rnd_ready_d", {31'd0, ifc.ready_d}, {31'd0, exp_rdy});
            chk("rnd_valid_e", {31'd0, ifc.valid_e}, {31'd0, m.vld});
            chk("rnd_regwrite_e", {31'd0, ifc.regwrite_e}, {31'd0, m.vld & m.regwrite});
            if (m.vld) begin
                chk("rnd_srca", ifc.SrcAE, ea);
                chk("rnd_writedata", ifc.writedata_e, eb);
                chk("rnd_srcb", ifc.SrcBE, m.alusrc ? m.imm : eb);
                chk("rnd_ins_e", {25'd0, ifc.ins_e}, {25'd0, m.ins});
                chk("rnd_rd_e", {27'd0, ifc.rd_e}, {27'd0, m.rd});
            end
            if (ifc.flush_e) begin
                m.vld = 0;
            end else if (ifc.valid_d && exp_rdy) begin
                m = '{vld: 1, ins: ifc.ins_d, a: ifc.rd1_d, b: ifc.rd2_d, imm: ifc.imm_d,
                      rs1: ifc.rs1_d, rs2: ifc.rs2_d, rd: ifc.rd_d,
                      alusrc: ifc.alusrc_d, regwrite: ifc.regwrite_d};
            end else if (m.vld && ifc.ready_e) begin
                m.vld = 0;
            end else if (m.vld) begin
                m.a = ea;
                m.b = eb;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid_d  in  1  decode stage presents an instruction.
- ready_d  out  1  stage can accept the decode instruction this cycle.
- ins_d  in  7  ALU op bundle: [6] opb5, [5] funct7b5, [4:2] funct3, [1:0] ALUOp.
- rd1_d, rd2_d, imm_d  in  32 each  register-file reads and the sign-extended immediate.
- rs1_d, rs2_d, rd_d  in  5 each  source and destination register indices.
- alusrc_d, regwrite_d  in  1 each  select imm_d for SrcB; writes register rd.
- rd_m, rd_w  in  5 each  destination registers of the MEM and WB stages.
- regwrite_m, regwrite_w  in  1 each  MEM and WB write enables.
- aluresult_m, result_w  in  32 each  MEM and WB forward values.
- flush_e  in  1  kill the held instruction (taken branch).
- valid_e  out  1  SrcAE, SrcBE and ins_e are valid.
- ready_e  in  1  ALU/MEM stage accepts this cycle.
- ins_e  out  7  registered op bundle toward the ALU.
- SrcAE, SrcBE  out  32 each  forwarded ALU operands.
- writedata_e  out  32  forwarded rs2 value (store data).
- rd_e  out  5  registered destination register.
- regwrite_e  out  1  registered write enable.

Function
REQ-002 A transfer in SHALL occur when valid_d and ready_d; a transfer out SHALL occur when valid_e and ready_e.
REQ-003 ready_d SHALL equal (~valid_e | ready_e) & ~flush_e; it is combinational and has no path from valid_d.
REQ-004 The stage SHALL be a one-entry register with two states: EMPTY (valid_e=0) and FULL (valid_e=1).
REQ-005 Transitions:
- EMPTY -> FULL on transfer in.
- FULL -> FULL on simultaneous transfer out and transfer in.
- FULL -> EMPTY on transfer out without transfer in.
- FULL holds while ready_e=0.
REQ-006 On transfer in, the stage SHALL capture ins_d, rd1_d, rd2_d, imm_d, rs1_d, rs2_d, rd_d, alusrc_d and regwrite_d at the clock edge; latency is exactly 1 cycle from decode to valid_e.
REQ-007 Operand A SHALL be forwarded from the registered rs1:
- aluresult_m if regwrite_m & rd_m==rs1 & rs1!=0;
- else result_w if regwrite_w & rd_w==rs1 & rs1!=0;
- else the registered rd1.
REQ-008 Operand B (writedata_e) SHALL be forwarded by the same rule using rs2 and rd2; MEM has priority over WB.
REQ-009 SrcBE SHALL be the registered imm when alusrc is set; otherwise it SHALL be writedata_e.
REQ-010 Register x0 SHALL never be forwarded, even if regwrite_m/w is set with rd=0.
REQ-011 While FULL and ready_e=0, the stage SHALL write the forwarded A and B values back into its rd1/rd2 registers every cycle, so a forward source that retires during the stall is not lost.
REQ-012 flush_e SHALL force valid_e=0 at the next edge and block transfer in that cycle; data registers may keep stale values, but regwrite_e SHALL read 0 whenever valid_e=0.
REQ-013 flush_e SHALL take priority over ready_e, valid_d and hold.
REQ-014 Forwarding and SrcA/SrcB muxing SHALL be purely combinational from registered state and the M/W inputs, with no added cycle.
REQ-015 All widths SHALL be exact with no truncation; index compares are 5-bit equality.

Reset
REQ-016 reset SHALL asynchronously force EMPTY: valid_e=0, regwrite_e=0, ins_e=0, rd_e=0 and all captured data and index registers to 0.
REQ-017 In reset, ready_d SHALL read 1 as soon as reset deasserts; an instruction held mid-operation when reset asserts SHALL be discarded, never emitted.

Verification
REQ-018 Basic pass-through: valid_d=1, ins_d=7'b0000010, rd1_d=5, rd2_d=7, alusrc_d=0, ready_e=1, no forwarding -> next cycle valid_e=1, SrcAE=5, SrcBE=7.
REQ-019 MEM-over-WB priority: rs1=3, regwrite_m=1, rd_m=3, aluresult_m=0x10; regwrite_w=1, rd_w=3, result_w=0x20 -> SrcAE=0x10.
REQ-020 x0 rule: rs2=0, regwrite_m=1, rd_m=0, aluresult_m=0xFFFF, rd2=0 -> writedata_e=0, SrcBE=0 (alusrc=0).
REQ-021 Stall refresh: FULL with ready_e=0, rs1=4 forwarded from WB value 0x99 for one cycle, then WB deasserts -> SrcAE stays 0x99 until transfer out.
REQ-022 Flush and back-to-back: flush_e=1 while FULL and valid_d=1 -> next cycle valid_e=0, ready_d was 0 that cycle; then continuous valid_d/ready_e -> one instruction out per cycle with no bubbles.
REQ-023 Reset mid-operation: assert reset while FULL with ready_e=0 -> valid_e=0 and regwrite_e=0 immediately, without waiting for a clock edge.
